// File: rtl/pong_pkg.sv
// Shared constants, encoder types and helpers for the pong game core.
// Latency: none (declarations only). Backpressure: none.
// Encoder bits idle high; detent is the 11 state.
package pong_pkg;
    localparam int SCREEN_H = 16;
    localparam int POS_W    = 4;

    localparam logic [1:0] DETENT   = 2'b11;
    localparam logic       ENC_IDLE = 1'b1;

    typedef struct packed {
        logic a;
        logic b;
    } enc_t;

    // Position of a quadrature state along the CW cycle 11 -> 10 -> 00 -> 01.
    function automatic logic [1:0] quad_idx(input enc_t e);
        return {~e.a, e.a ^ e.b};
    endfunction

    function automatic logic [SCREEN_H-1:0] paddle_mask(input logic [POS_W-1:0] pos,
                                                         input int len);
        logic [SCREEN_H-1:0] run;
        run = '0;
        for (int i = 0; i < SCREEN_H; i++) run[i] = (i < len);
        return run << pos;
    endfunction
endpackage

// File: rtl/paddle_ctrl_if.sv
// Encoder inputs and paddle/entropy outputs of the paddle controller.
// Latency: none (wiring). Backpressure: none.
// master drives the encoders, slave is the controller.
interface paddle_ctrl_if;
    logic                           l_a;
    logic                           l_b;
    logic                           r_a;
    logic                           r_b;
    logic [pong_pkg::SCREEN_H-1:0]  lpaddle;
    logic [pong_pkg::SCREEN_H-1:0]  rpaddle;
    logic [4:0]                     entropy;

    modport master (output l_a, l_b, r_a, r_b, input lpaddle, rpaddle, entropy);
    modport slave  (input l_a, l_b, r_a, r_b, output lpaddle, rpaddle, entropy);
endinterface

// File: rtl/paddle_ctrl_quad_decoder.sv
// One player's encoder: sync, debounce, quadrature decode, saturating position.
// Latency: raw edge to pos change is DEBOUNCE+3 clocks. Backpressure: none.
// Glitches shorter than DEBOUNCE samples are dropped.
module quad_decoder
    import pong_pkg::*;
#(
    parameter int PADDLE_LEN = 3,
    parameter int DEBOUNCE   = 3
) (
    input  logic             game_clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic             a_sync,
    output logic [POS_W-1:0] pos
);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(SCREEN_H - PADDLE_LEN);
    localparam logic [POS_W-1:0] CENTRE  = POS_W'((SCREEN_H - PADDLE_LEN) / 2);
    localparam logic [3:0]       DB_LAST = 4'(DEBOUNCE - 1);

    // Bit 1 is phase A, bit 0 is phase B throughout.
    logic [1:0]        s1, s2, filt, prev;
    logic [3:0]        cnt [2];
    logic signed [2:0] acc;
    logic signed [3:0] acc_nxt;
    logic [1:0]        step;

    assign a_sync = s2[1];

    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) begin
            s1   <= {2{ENC_IDLE}};
            s2   <= {2{ENC_IDLE}};
            filt <= {2{ENC_IDLE}};
            cnt  <= '{default: '0};
        end else begin
            s1 <= {enc_a, enc_b};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != filt[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        filt[i] <= s2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // step: 1 = CW quarter, 3 = CCW quarter, 2 = both bits flipped (invalid).
    always_comb begin
        step    = quad_idx(enc_t'(filt)) - quad_idx(enc_t'(prev));
        acc_nxt = {acc[2], acc};
        if (step == 2'd1)      acc_nxt = acc_nxt + 4'sd1;
        else if (step == 2'd3) acc_nxt = acc_nxt - 4'sd1;
    end

    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) begin
            prev <= DETENT;
            acc  <= '0;
            pos  <= CENTRE;
        end else begin
            prev <= filt;
            if (filt != prev) begin
                if (step == 2'd2 || filt == DETENT) begin
                    acc <= '0;
                    if (step != 2'd2) begin
                        if (acc_nxt == 4'sd4 && pos != POS_MAX)
                            pos <= pos + POS_W'(1);
                        else if (acc_nxt == -4'sd4 && pos != '0)
                            pos <= pos - POS_W'(1);
                    end
                end else begin
                    acc <= acc_nxt[2:0];
                end
            end
        end
    end
endmodule

// File: rtl/paddle_ctrl.sv
// Two-player encoder front end: paddle row masks plus a serve entropy word.
// Latency: masks follow position combinationally; entropy steps every clock. Backpressure: none.
// Players are independent; simultaneous moves apply in the same cycle.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int PADDLE_LEN = 3,
    parameter int DEBOUNCE   = 3
) (
    input  logic          game_clk,
    input  logic          reset,
    paddle_ctrl_if.slave  bus
);
    logic [POS_W-1:0] lpos, rpos;
    logic             l_sync, r_sync;
    logic [4:0]       lfsr, lfsr_nxt;

    quad_decoder #(.PADDLE_LEN(PADDLE_LEN), .DEBOUNCE(DEBOUNCE)) u_left (
        .game_clk (game_clk),
        .reset    (reset),
        .enc_a    (bus.l_a),
        .enc_b    (bus.l_b),
        .a_sync   (l_sync),
        .pos      (lpos)
    );

    quad_decoder #(.PADDLE_LEN(PADDLE_LEN), .DEBOUNCE(DEBOUNCE)) u_right (
        .game_clk (game_clk),
        .reset    (reset),
        .enc_a    (bus.r_a),
        .enc_b    (bus.r_b),
        .a_sync   (r_sync),
        .pos      (rpos)
    );

    assign bus.lpaddle = paddle_mask(lpos, PADDLE_LEN);
    assign bus.rpaddle = paddle_mask(rpos, PADDLE_LEN);
    assign bus.entropy = lfsr;

    // x^5+x^3+1 feedback, stirred by player phase A; all-zero lock-up is escaped.
    always_comb begin
        lfsr_nxt = {lfsr[3:0], lfsr[4] ^ lfsr[2] ^ l_sync ^ r_sync};
        if (lfsr_nxt == 5'd0) lfsr_nxt = 5'd1;
    end

    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) lfsr <= 5'd1;
        else        lfsr <= lfsr_nxt;
    end
endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus pushes timed expectations, a monitor checks them.
module tb_paddle_ctrl;
    localparam int PL     = 3;
    localparam int DB     = 3;
    localparam int CENTRE = (16 - PL) / 2;
    localparam int PMAX   = 16 - PL;

    logic game_clk = 1'b0;
    logic reset    = 1'b0;

    paddle_ctrl_if bus();

    paddle_ctrl #(.PADDLE_LEN(PL), .DEBOUNCE(DB)) dut (
        .game_clk (game_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 game_clk = ~game_clk;

    typedef struct {
        int          cyc;
        int          ch;
        logic [15:0] val;
    } exp_t;

    exp_t       sb[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    int         lpos   = CENTRE;
    int         rpos   = CENTRE;
    logic [4:0] ent_model;

    always @(posedge game_clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_mask(input int p);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = (i >= p) && (i < p + PL);
        return m;
    endfunction

    function automatic int sat(input int p);
        if (p < 0) return 0;
        if (p > PMAX) return PMAX;
        return p;
    endfunction

    function automatic logic [4:0] lfsr_step(input logic [4:0] e);
        logic [4:0] n;
        n = {e[3:0], e[4] ^ e[2]};
        return (n == 5'd0) ? 5'd1 : n;
    endfunction

    function automatic void push(input int c, input int ch, input logic [15:0] v);
        exp_t e;
        e.cyc = c;
        e.ch  = ch;
        e.val = v;
        sb.push_back(e);
    endfunction

    // Monitor: compares every expectation due this cycle, away from the active edge.
    always @(negedge game_clk) begin
        logic [15:0] act;
        string       nm;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].ch)
                    0:       begin act = bus.lpaddle;          nm = "lpaddle"; end
                    1:       begin act = bus.rpaddle;          nm = "rpaddle"; end
                    default: begin act = {11'd0, bus.entropy}; nm = "entropy"; end
                endcase
                checks++;
                if (sb[i].cyc < cyc || act !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cycle %0d (due %0d): got %h, expected %h",
                             nm, cyc, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (bus.entropy == 5'd0) begin
            errors++;
            $display("FAIL entropy_nonzero cycle %0d: got %h, expected nonzero", cyc, bus.entropy);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge game_clk);
            #1;
        end
    endtask

    task automatic drive(input bit dl, input bit dr, input logic [1:0] ab);
        if (dl) {bus.l_a, bus.l_b} = ab;
        if (dr) {bus.r_a, bus.r_b} = ab;
    endtask

    // Full detent; checks the mask one edge before and exactly at DB+3 edges after the last change.
    task automatic detent(input bit dl, input bit dr, input bit cw, input int hold);
        logic [1:0] seq [4];
        if (cw) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        else    seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            drive(dl, dr, seq[i]);
            if (i == 3) begin
                if (dl) begin
                    push(cyc + DB + 2, 0, model_mask(lpos));
                    lpos = sat(lpos + (cw ? 1 : -1));
                    push(cyc + DB + 3, 0, model_mask(lpos));
                end
                if (dr) begin
                    push(cyc + DB + 2, 1, model_mask(rpos));
                    rpos = sat(rpos + (cw ? 1 : -1));
                    push(cyc + DB + 3, 1, model_mask(rpos));
                end
            end
            tick(hold);
        end
    endtask

    task automatic expect_still(input bit dl, input bit dr);
        if (dl) push(cyc + DB + 6, 0, model_mask(lpos));
        if (dr) push(cyc + DB + 6, 1, model_mask(rpos));
        tick(DB + 8);
    endtask

    task automatic half_turn(input bit dl, input bit dr, input bit cw);
        logic [1:0] seq [4];
        if (cw) seq = '{2'b10, 2'b00, 2'b10, 2'b11};
        else    seq = '{2'b01, 2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 4; i++) begin
            drive(dl, dr, seq[i]);
            tick(8);
        end
        expect_still(dl, dr);
    endtask

    task automatic glitch(input bit right, input bit on_a, input int len);
        logic [1:0] g;
        g = on_a ? 2'b01 : 2'b10;
        drive(!right, right, g);
        tick(len);
        drive(!right, right, 2'b11);
        expect_still(!right, right);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bus.l_a = 1'b1; bus.l_b = 1'b1; bus.r_a = 1'b1; bus.r_b = 1'b1;
        reset = 1'b0;
        tick(3);
        push(cyc, 0, 16'h01C0);
        push(cyc, 1, 16'h01C0);
        push(cyc, 2, 16'h0001);
        tick(1);

        // Release; entropy follows the free-running LFSR with idle inputs.
        reset = 1'b1;
        ent_model = 5'd1;
        for (int j = 0; j <= 100; j++) begin
            push(cyc + j, 2, {11'd0, ent_model});
            ent_model = lfsr_step(ent_model);
        end
        push(cyc + 50, 0, 16'h01C0);
        push(cyc + 50, 1, 16'h01C0);
        tick(102);

        detent(1, 0, 1, 8);
        push(cyc, 1, model_mask(rpos));
        tick(2);

        for (int k = 0; k < 20; k++) detent(0, 1, 0, $urandom_range(DB + 1, 8));
        for (int k = 0; k < 20; k++) detent(0, 1, 1, $urandom_range(DB + 1, 8));

        detent(1, 0, 0, 8);
        glitch(0, 1, 2);
        half_turn(1, 0, 1);

        drive(1, 0, 2'b00); tick(8);
        drive(1, 0, 2'b01); tick(8);
        drive(1, 0, 2'b11); tick(8);
        expect_still(1, 0);

        detent(1, 1, 1, 6);
        detent(1, 1, 0, 6);

        for (int k = 0; k < 40; k++) begin
            int op;
            bit dl, dr;
            op = $urandom_range(0, 3);
            dl = 1'($urandom_range(0, 1));
            dr = !dl || ($urandom_range(0, 1) == 1);
            case (op)
                0, 1:    detent(dl, dr, 1'($urandom_range(0, 1)), $urandom_range(DB + 1, 8));
                2:       glitch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                $urandom_range(1, DB - 1));
                default: half_turn(dl, dr, 1'($urandom_range(0, 1)));
            endcase
        end

        // Reset in the middle of a detent with the left paddle at row 9.
        while (lpos < 9) detent(1, 0, 1, 5);
        while (lpos > 9) detent(1, 0, 0, 5);
        drive(1, 0, 2'b10); tick(8);
        drive(1, 0, 2'b00); tick(8);
        reset = 1'b0;
        lpos  = CENTRE;
        rpos  = CENTRE;
        push(cyc, 0, 16'h01C0);
        push(cyc, 1, 16'h01C0);
        push(cyc, 2, 16'h0001);
        drive(1, 1, 2'b11);
        tick(3);
        reset = 1'b1;
        tick(2);
        detent(1, 0, 1, 8);
        push(cyc, 0, 16'h0380);
        tick(DB + 8);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Upstream stage of the game core. Converts two players' quadrature rotary-encoder inputs into the 16-bit paddle row masks `lpaddle` and `rpaddle` that the game core consumes.
- Also produces the 5-bit `entropy` word used for ball serve randomisation.
- Per input bit: synchronise, then debounce. Per player: decode quadrature, keep a saturating paddle position, emit a one-hot-run row mask.
- Runs on the 1 kHz game clock.

Parameters:
- PADDLE_LEN, 3: paddle height in rows (1..8).
- DEBOUNCE, 3: consecutive differing samples required before a filtered encoder bit changes (1..15).

Ports:
- game_clk  in  1  1 kHz game clock.
- reset  in  1  asynchronous, active-low reset.
- l_a  in  1  left encoder phase A (raw, asynchronous).
- l_b  in  1  left encoder phase B (raw, asynchronous).
- r_a  in  1  right encoder phase A (raw, asynchronous).
- r_b  in  1  right encoder phase B (raw, asynchronous).
- lpaddle  out  16  left paddle mask; bit i set = row i occupied.
- rpaddle  out  16  right paddle mask; bit i set = row i occupied.
- entropy  out  5  free-running random word.

Behaviour:
- Reset (reset low, asynchronous, immediate, also mid-operation):
  - Position = CENTRE = (16-PADDLE_LEN)/2, i.e. 6 at default.
  - lpaddle = rpaddle = 16'h01C0 at default.
  - Sync flops and filtered bits = 1 (encoder idle at detent 11).
  - Debounce counters = 0; quarter accumulators = 0.
  - entropy = 5'b00001.
- Synchroniser: 2 flops per raw bit.
- Debounce, per bit:
  - If sync != filtered: counter increments.
  - When the counter would reach DEBOUNCE: filtered <= sync and counter <= 0.
  - Any cycle with sync == filtered clears the counter. Pulses shorter than DEBOUNCE samples are never passed on.
- Quadrature decode on the filtered pair (A,B):
  - CW sequence is 11→10→00→01→11; each CW quarter step adds 1 to a signed 3-bit accumulator. The reverse sequence subtracts 1.
  - Both bits changing in the same cycle is invalid: ignore it and clear the accumulator.
  - On arrival at 11 (detent): acc == +4 → pos+1; acc == -4 → pos-1; otherwise no move. The accumulator clears at every detent arrival.
  - A half turn followed by a return produces no move.
- Position:
  - 4-bit, saturating in 0..16-PADDLE_LEN (13 at default). Increments at max and decrements at 0 are dropped.
  - CW moves the paddle toward row 15.
- Masks: combinational from the position register: bits pos..pos+PADDLE_LEN-1 set. At default, pos 0 gives 16'h0007 and pos 13 gives 16'hE000.
- Latency:
  - Count the first edge that samples the raw change as edge 1.
  - Filtered bit updates on edge DEBOUNCE+2.
  - Position and mask update on edge DEBOUNCE+3 (edge 6 at default).
- Entropy:
  - 5-bit Fibonacci LFSR, taps x^5+x^3+1, steps every cycle.
  - Bit 0 of the next value is additionally XORed with (l_a ^ r_a) taken from the second sync stage, before debounce.
  - If the next value would be 5'b00000, load 5'b00001 instead. entropy is never zero.
- The two players are fully independent. Simultaneous moves on both sides are both applied in the same cycle.

Decomposition:
- Shared package pong_pkg:
  - SCREEN_H = 16.
  - POS_W = 4.
  - Detent code 2'b11.
  - Idle/reset constant for encoder bits.
- One sub-module, quad_decoder, instantiated twice (left, right). It contains the synchronisers, the debounce for both bits, the decoder, the accumulator and the saturating position, and outputs pos[3:0].
- The top level holds mask generation and the entropy LFSR.

Test Plan:
- Reset release with inputs at 11 → lpaddle = rpaddle = 16'h01C0; entropy = 5'b00001, then steps to a nonzero value every cycle for 100 cycles.
- One CW detent on left (each phase held 8 cycles) → lpaddle = 16'h0380 exactly DEBOUNCE+3 edges after the final 01→11 change; rpaddle stays 16'h01C0.
- 20 CCW detents on right → rpaddle reaches 16'h0007 after 6 detents and holds. Then 20 CW detents → 16'hE000 and holds.
- Glitch of 2 cycles (< DEBOUNCE) on l_a, and a half turn 11→10→00→10→11 → lpaddle unchanged at 16'h01C0.
- Simultaneous A and B flip (11→00) followed by 00→01→11 → no position change (invalid step clears the accumulator).
- Assert reset low mid-detent (accumulator at +2, pos 9) → masks immediately return to 16'h01C0. After release, a full CW detent yields 16'h0380.
